sized_data_memory: RTL and testbench

SIZED_DATA_MEMORY -- requirements
Module: sized_data_memory

---
 rtl/sized_data_memory_pkg.sv | 29 ++
 rtl/sized_data_memory_lane_align.sv | 60 ++++++
 rtl/sized_data_memory.sv | 96 +++++++++
 tb/tb_sized_data_memory.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sized_data_memory_pkg.sv
// Shared definitions for the sized data memory.
//   size_e        : access size encoding carried on the Size port
//   access_fault  : decides whether a request must be rejected
//                   (illegal size, misaligned half/word, or address past the end)
package sized_data_memory_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  // limit is the memory size in bytes; 33 bits so that a 4 GiB array still fits.
  function automatic logic access_fault(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input logic [32:0] limit);
    logic bad;
    case (size_e'(size))
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    if ({1'b0, addr} >= limit) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/sized_data_memory_lane_align.sv
// mem_lane_align: combinational byte-lane steering between a right-aligned
// byte/half/word value and its position inside a 32-bit memory word.
//   size       : access size (size_e encoding)
//   zero_ext   : 1 zero-extends sub-word loads, 0 sign-extends
//   offset     : byte offset of the access inside the word
//   store_data : right-aligned store value
//   load_word  : full memory word being read
//   byte_en    : lanes written by a store
//   store_word : store value placed on its lanes
//   load_data  : extracted and extended load value
// BIG_ENDIAN selects whether byte offset 0 lives on bits [7:0] (0) or [31:24] (1).
module mem_lane_align
  import sized_data_memory_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  logic [2:0]  nbytes;
  logic [3:0]  mask;
  logic [1:0]  shift;
  logic [31:0] shifted;

  always_comb begin
    nbytes = 3'd4;
    mask   = 4'b1111;
    case (size_e'(size))
      SZ_BYTE: begin nbytes = 3'd1; mask = 4'b0001; end
      SZ_HALF: begin nbytes = 3'd2; mask = 4'b0011; end
      default: begin nbytes = 3'd4; mask = 4'b1111; end
    endcase

    // Lowest lane occupied by the access. In big-endian order the first byte
    // of the access is the most significant, so the run of lanes ends at
    // lane (3 - offset). Misaligned combinations are rejected upstream.
    if (BIG_ENDIAN) shift = 2'(3'd4 - {1'b0, offset} - nbytes);
    else            shift = offset;

    byte_en    = mask << shift;
    store_word = store_data << {shift, 3'b000};
    shifted    = load_word >> {shift, 3'b000};

    case (size_e'(size))
      SZ_BYTE: load_data = zero_ext ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = zero_ext ? {16'h0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// sized_data_memory: byte-addressed data memory of DEPTH_WORDS 32-bit words
// supporting byte, half and word loads/stores with one-cycle read latency.
//   Clk, Rst_n   : clock, synchronous active-low reset (array is not cleared)
//   MemRead      : read request
//   MemWrite     : write request (both together: read returns pre-write data)
//   Size         : 00 byte, 01 half, 10 word, 11 illegal
//   Unsigned     : zero- (1) or sign- (0) extension of sub-word loads
//   Address      : byte address
//   DataIn       : right-aligned store data
//   DataOut      : right-aligned, extended load result (held between reads)
//   ReadValid    : one-cycle pulse when DataOut is refreshed
//   Fault        : one-cycle pulse after a rejected request
//   FaultSticky  : set by any rejected request, cleared by reset only
module sized_data_memory
  import sized_data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter bit BIG_ENDIAN  = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        ReadValid,
  output logic        Fault,
  output logic        FaultSticky
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          req;
  logic          bad;
  logic          rd_ok;
  logic          wr_ok;
  logic [31:0]   rd_word;
  logic [3:0]    byte_en;
  logic [31:0]   store_word;
  logic [31:0]   load_data;

  assign idx     = Address[AW+1:2];
  assign req     = MemRead | MemWrite;
  assign bad     = access_fault(Size, Address, LIMIT);
  // Requests seen while in reset are dropped entirely.
  assign rd_ok   = Rst_n & MemRead  & ~bad;
  assign wr_ok   = Rst_n & MemWrite & ~bad;
  // Combinational array read: registering it on the same edge as a write
  // yields read-before-write for simultaneous read and write.
  assign rd_word = mem[idx];

  mem_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .size       (Size),
    .zero_ext   (Unsigned),
    .offset     (Address[1:0]),
    .store_data (DataIn),
    .load_word  (rd_word),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_data  (load_data)
  );

  // Array update: per-lane write, contents survive reset.
  always_ff @(posedge Clk) begin
    if (wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  // Output stage: load result, valid and fault pulses, one cycle after sampling.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      DataOut     <= 32'h0;
      ReadValid   <= 1'b0;
      Fault       <= 1'b0;
      FaultSticky <= 1'b0;
    end else begin
      ReadValid <= rd_ok;
      Fault     <= req & bad;
      if (req & bad) FaultSticky <= 1'b1;
      if (rd_ok)     DataOut     <= load_data;
    end
  end

endmodule

// File: tb/tb_sized_data_memory.sv
module tb_sized_data_memory;

  localparam int DEPTH = 256;
  localparam bit BE    = 1'b0;
  localparam int NBYTE = 4 * DEPTH;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        Unsigned = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] DataIn = 32'h0;
  logic [31:0] DataOut;
  logic        ReadValid;
  logic        Fault;
  logic        FaultSticky;

  sized_data_memory #(.DEPTH_WORDS(DEPTH), .BIG_ENDIAN(BE)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Size(Size), .Unsigned(Unsigned), .Address(Address), .DataIn(DataIn),
    .DataOut(DataOut), .ReadValid(ReadValid), .Fault(Fault),
    .FaultSticky(FaultSticky)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: byte-addressed memory plus expected output registers.
  logic [7:0]  mb [NBYTE];
  logic [31:0] init_words [DEPTH];
  logic [31:0] m_dout = 32'h0;
  bit          m_rv = 1'b0;
  bit          m_fault = 1'b0;
  bit          m_sticky = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                            input logic [31:0] addr, input logic [31:0] din, input bit rstn);
    int n;
    logic [31:0] val;
    bit bad;
    if (!rstn) begin
      m_dout = 0; m_rv = 0; m_fault = 0; m_sticky = 0;
      return;
    end
    m_rv = 0;
    m_fault = 0;
    if (!(rd || wr)) return;
    bad = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0)
          || (addr >= NBYTE);
    if (bad) begin
      m_fault = 1; m_sticky = 1;
      return;
    end
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (rd) begin
      val = 0;
      for (int k = 0; k < n; k++) begin
        if (BE) val = (val << 8) | 32'(mb[addr + k]);
        else    val = val | (32'(mb[addr + k]) << (8 * k));
      end
      if (n < 4 && !uns && val[8*n-1]) val = val | ~((32'h1 << (8 * n)) - 1);
      m_dout = val;
      m_rv = 1;
    end
    if (wr) begin
      for (int k = 0; k < n; k++) begin
        if (BE) mb[addr + k] = din[8*(n-1-k) +: 8];
        else    mb[addr + k] = din[8*k +: 8];
      end
    end
  endtask

  // Drive one request, let one rising edge sample it, then settle for checking.
  task automatic apply(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] din, input bit rstn);
    MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns;
    Address = addr; DataIn = din; Rst_n = rstn;
    @(posedge Clk);
    model_edge(rd, wr, sz, uns, addr, din, rstn);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " DataOut"}, DataOut, m_dout);
    check({tag, " ReadValid"}, 32'(ReadValid), 32'(m_rv));
    check({tag, " Fault"}, 32'(Fault), 32'(m_fault));
    check({tag, " FaultSticky"}, 32'(FaultSticky), 32'(m_sticky));
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] din;
    bit          hold;    // DataOut expected to keep its previous value
    logic [31:0] dout;
    bit          rv;
    bit          fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rd, bit wr, logic [1:0] sz, bit uns, logic [31:0] addr,
                              logic [31:0] din, bit hold, logic [31:0] dout, bit rv, bit fault);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.din = din;
    v.hold = hold; v.dout = dout; v.rv = rv; v.fault = fault;
    return v;
  endfunction

  initial begin
    logic [31:0] last;
    logic [31:0] w;
    logic [1:0]  sz;
    logic [31:0] addr;

    // Reset state
    apply(0, 0, 2'd0, 0, 0, 0, 0);
    apply(1, 1, 2'd3, 0, 32'hFFFF_FFFF, 0, 0);
    check("reset DataOut", DataOut, 32'h0);
    check("reset ReadValid", 32'(ReadValid), 32'h0);
    check("reset Fault", 32'(Fault), 32'h0);
    check("reset FaultSticky", 32'(FaultSticky), 32'h0);

    // Fill the whole array with known contents
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      init_words[i] = w;
      apply(0, 1, 2'd2, 0, 32'(4 * i), w, 1);
      check_model($sformatf("init%0d", i));
    end

    // Directed vectors (expected values are little-endian except where BE noted)
    vecs.push_back(mk(0,1,2'd2,0,32'h40,32'h1234ABCD, 1,0,0,0));
    vecs.push_back(mk(1,0,2'd2,0,32'h40,0,            0,32'h1234ABCD,1,0));
    vecs.push_back(mk(0,0,2'd0,0,32'h40,0,            1,0,0,0));
    vecs.push_back(mk(0,1,2'd2,0,32'h28,32'h0001FFFF, 1,0,0,0));
    vecs.push_back(mk(1,0,2'd1,0,32'h28,0,            0,32'hFFFFFFFF,1,0));
    vecs.push_back(mk(1,0,2'd1,1,32'h28,0,            0,32'h0000FFFF,1,0));
    vecs.push_back(mk(1,0,2'd1,0,32'h2A,0,            0,32'h00000001,1,0));
    vecs.push_back(mk(0,1,2'd2,0,32'h10,32'h0,        1,0,0,0));
    vecs.push_back(mk(0,1,2'd0,0,32'h13,32'hABCDEF80, 1,0,0,0));
    vecs.push_back(mk(1,0,2'd0,0,32'h13,0,            0,32'hFFFFFF80,1,0));
    vecs.push_back(mk(1,0,2'd0,1,32'h13,0,            0,32'h00000080,1,0));
    vecs.push_back(mk(1,0,2'd2,0,32'h10,0,            0,BE ? 32'h00000080 : 32'h80000000,1,0));
    vecs.push_back(mk(1,0,2'd2,0,32'h42,0,            1,0,0,1));
    vecs.push_back(mk(0,1,2'd1,0,32'h43,32'hDEAD,     1,0,0,1));
    vecs.push_back(mk(1,0,2'd3,0,32'h40,0,            1,0,0,1));
    vecs.push_back(mk(1,0,2'd2,0,32'h400,0,           1,0,0,1));
    vecs.push_back(mk(1,0,2'd2,0,32'h40,0,            0,32'h1234ABCD,1,0));
    vecs.push_back(mk(0,1,2'd2,0,32'h50,32'h11111111, 1,0,0,0));
    vecs.push_back(mk(1,1,2'd2,0,32'h50,32'h22222222, 0,32'h11111111,1,0));
    vecs.push_back(mk(1,0,2'd2,0,32'h50,0,            0,32'h22222222,1,0));

    last = DataOut;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].din, 1);
      if (!vecs[i].hold) last = vecs[i].dout;
      check($sformatf("vec%0d DataOut", i), DataOut, last);
      check($sformatf("vec%0d ReadValid", i), 32'(ReadValid), 32'(vecs[i].rv));
      check($sformatf("vec%0d Fault", i), 32'(Fault), 32'(vecs[i].fault));
      check($sformatf("vec%0d FaultSticky", i), 32'(FaultSticky), 32'(m_sticky));
    end
    check("sticky after faults", 32'(FaultSticky), 32'h1);

    // Reset with a read just completed and a store issued under reset
    apply(1, 0, 2'd2, 0, 32'h40, 0, 1);
    check("pre-reset lw DataOut", DataOut, 32'h1234ABCD);
    check("pre-reset lw ReadValid", 32'(ReadValid), 32'h1);
    apply(0, 1, 2'd2, 0, 32'h60, 32'h33333333, 0);
    check("rst DataOut", DataOut, 32'h0);
    check("rst ReadValid", 32'(ReadValid), 32'h0);
    check("rst Fault", 32'(Fault), 32'h0);
    check("rst FaultSticky", 32'(FaultSticky), 32'h0);
    apply(1, 0, 2'd2, 0, 32'h60, 0, 0);
    apply(0, 0, 2'd0, 0, 0, 0, 1);
    check("lw under reset dropped ReadValid", 32'(ReadValid), 32'h0);
    check("lw under reset dropped DataOut", DataOut, 32'h0);
    apply(1, 0, 2'd2, 0, 32'h60, 0, 1);
    check("word 0x60 unchanged", DataOut, init_words[32'h60 / 4]);
    check("word 0x60 ReadValid", 32'(ReadValid), 32'h1);
    apply(1, 0, 2'd2, 0, 32'h50, 0, 1);
    check("word 0x50 after reset", DataOut, 32'h22222222);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = $urandom_range(0, NBYTE - 1);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) addr[0] = 1'b0;
        if (sz == 2'd2) addr[1:0] = 2'b00;
      end
      if ($urandom_range(0, 19) == 0) addr = NBYTE + $urandom_range(0, 4095);
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            addr, $urandom, ($urandom_range(0, 39) != 0));
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
